// File: rtl/rom_arb_pkg.sv
// Shared helpers for the ROM read arbiter: tag sizing, one-hot decode and
// modulo-N rotations over a fixed 16-bit working width.
package rom_arb_pkg;

  localparam int MAXN = 16;
  localparam int MAXW = $clog2(MAXN);

  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Rotations wrap modulo n, so bits at or above n stay zero.
  function automatic logic [MAXN-1:0] rot_right(input logic [MAXN-1:0] v,
                                                input int sh, input int n);
    logic [MAXN-1:0] r;
    r = '0;
    for (int i = 0; i < MAXN; i++)
      if (i < n) r[MAXW'(i)] = v[MAXW'((i + sh) % n)];
    return r;
  endfunction

  function automatic logic [MAXN-1:0] rot_left(input logic [MAXN-1:0] v,
                                               input int sh, input int n);
    logic [MAXN-1:0] r;
    r = '0;
    for (int i = 0; i < MAXN; i++)
      if (i < n) r[MAXW'((i + sh) % n)] = v[MAXW'(i)];
    return r;
  endfunction

  function automatic logic [MAXW-1:0] onehot_to_idx(input logic [MAXN-1:0] oh);
    logic [MAXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAXN; i++)
      if (oh[i]) idx = idx | MAXW'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_pri_arb.sv
// Combinational round-robin picker: the first asserted req at or after ptr
// (wrapping) wins.
module rr_pri_arb
  import rom_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = tag_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] win
);

  logic [MAXN-1:0] req_ext;
  logic [MAXN-1:0] rot;
  logic [MAXN-1:0] pick;
  logic [MAXN-1:0] gnt_ext;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    req_ext         = '0;
    req_ext[N-1:0]  = req;
    rot             = rot_right(req_ext, int'(ptr), N);
    // Descending scan: the lowest set bit of the rotated vector is kept.
    pick = '0;
    for (int i = MAXN - 1; i >= 0; i--)
      if (rot[i]) begin
        pick             = '0;
        pick[MAXW'(i)]   = 1'b1;
      end
    gnt_ext = rot_left(pick, int'(ptr), N);
    gnt     = gnt_ext[N-1:0];
    win     = IW'(onehot_to_idx(gnt_ext));
  end

endmodule

// File: rtl/rom_rd_arb.sv
// Round-robin read arbiter sharing one 1-cycle-latency ROM among NREQ
// requesters; data returns to the winner one cycle after its grant.
module rom_rd_arb
  import rom_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int DW   = 16,
  parameter  int AW   = 8,
  localparam int IDW  = tag_width(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rom_ce,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] tag;
  logic           tag_valid;

  rr_pri_arb #(.N(NREQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .win (win)
  );

  assign rom_ce = |gnt;

  // gnt is one-hot, so OR-ing the gated addresses is the mux.
  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) rom_addr = rom_addr | req_addr[i*AW +: AW];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (rom_ce) begin
      ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Tag tracks the read in flight; reset drops it so no stale response leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag       <= '0;
      tag_valid <= 1'b0;
    end else begin
      tag_valid <= rom_ce;
      if (rom_ce) tag <= win;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++)
      rsp_valid[i] = tag_valid && (tag == IDW'(i));
  end

  // No data register: total table latency stays one cycle.
  assign rsp_data = rom_data;

endmodule

// File: tb/tb_rom_rd_arb.sv
// Scoreboard bench for rom_rd_arb: a reference model predicts each grant,
// queues the expected response, and a separate monitor checks responses.
module tb_rom_rd_arb;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rom_ce;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data = '0;

  rom_rd_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  always #5 clk = ~clk;

  // Sine-table stand-in: registered address, 1-cycle read latency.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) if (rom_ce) rom_data <= mem[rom_addr];

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t            q[$];
  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;
  int              ptr_m = 0;
  int              wait_c [NREQ];
  logic [NREQ-1:0] last_gnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: scan the requests from the priority pointer, wrapping.
  always @(negedge clk) begin
    int              w;
    int              j;
    logic [NREQ-1:0] exp_g;
    logic [AW-1:0]   exp_a;
    exp_t            e;
    if (!rst_n) begin
      ptr_m = 0;
      q.delete();
      for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    end
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (ptr_m + k) % NREQ;
      if (req[j] && w < 0) w = j;
    end
    exp_g = '0;
    exp_a = '0;
    if (w >= 0) begin
      exp_g[w] = 1'b1;
      exp_a    = req_addr[w*AW +: AW];
    end
    check("gnt", 32'(gnt), 32'(exp_g));
    check("rom_ce", 32'(rom_ce), 32'(w >= 0));
    check("rom_addr", 32'(rom_addr), 32'(exp_a));
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && exp_g[i]) begin
          check("fairness_wait", 32'(wait_c[i] <= NREQ - 1), 32'd1);
          wait_c[i] = 0;
        end else if (req[i]) wait_c[i]++;
        else wait_c[i] = 0;
      end
      if (w >= 0) begin
        e.idx  = w;
        e.data = mem[exp_a];
        e.cyc  = cyc;
        q.push_back(e);
        ptr_m = (w + 1) % NREQ;
      end
    end
    last_gnt = exp_g;
  end

  // Monitor: each queued grant must be answered exactly one cycle later.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_v;
    exp_t            e;
    if (!rst_n) begin
      check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc - 1) begin
        check("rsp_latency", 32'(q[0].cyc), 32'(cyc - 1));
        void'(q.pop_front());
      end
      exp_v = '0;
      if (q.size() > 0 && q[0].cyc == cyc - 1) begin
        e = q.pop_front();
        exp_v[e.idx] = 1'b1;
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom);
  endfunction

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;

    // Idle after reset.
    #1;
    do_reset();
    repeat (20) step();

    // Single requester 2 at 0x40; it drops req the cycle after its grant.
    set_addr(2, 8'h40);
    req = 4'b0100;
    step();
    req = '0;
    repeat (3) step();

    // All four continuously from reset.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_addr(i, AW'(i * 16));
    req = '1;
    repeat (12) step();
    req = '0;
    step();

    // Fairness: 0..2 always requesting, requester 3 joins at cycle 5.
    do_reset();
    req = 4'b0111;
    repeat (5) step();
    set_addr(3, 8'hff);
    req[3] = 1'b1;
    repeat (10) step();
    req = '0;
    step();

    // Withdrawal: requester 1 loses to 0, then drops.
    do_reset();
    set_addr(0, 8'h05);
    set_addr(1, 8'h06);
    req = 4'b0011;
    step();
    req = '0;
    step();
    req = 4'b0010;
    step();
    req = '0;
    step();

    // Single requester stuck high: granted every cycle.
    set_addr(1, 8'hff);
    req = 4'b0010;
    repeat (8) step();
    req = '0;
    step();

    // Reset while requester 2's read is in flight.
    set_addr(2, 8'h22);
    req = 4'b0100;
    step();
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
    req   = '1;
    repeat (4) step();
    req = '0;
    step();

    // Randomised traffic obeying the hold-until-granted protocol.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && last_gnt[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          set_addr(i, rand_addr());
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_addr(i, rand_addr());
        end
      end
      step();
    end
    req = '0;
    repeat (3) step();
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
